lockstep_recovery_ctrl: RTL and testbench

LOCKSTEP_RECOVERY_CTRL -- requirements
Module: lockstep_recovery_ctrl

---
 rtl/ft_pkg.sv | 16 +
 rtl/lockstep_recovery_ctrl.sv | 123 ++++++++++++
 tb/tb_lockstep_recovery_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ft_pkg.sv
// Shared lockstep fault-tolerance types and default parameter values.
package ft_pkg;

    typedef enum logic [1:0] {
        StRun,
        StHalt,
        StRecover,
        StFatal
    } state_e;

    localparam int unsigned DefMaxRetry    = 3;
    localparam int unsigned DefClearWindow = 64;
    localparam int unsigned DefAckTimeout  = 16;
    localparam int unsigned DefCntWidth    = 8;

endpackage

// File: rtl/lockstep_recovery_ctrl.sv
// Dual-core lockstep supervisor: gates commits, halts on qualified mismatch and drives
// checkpoint recovery with bounded retries and acknowledge timeout.
module lockstep_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int unsigned MAX_RETRY    = DefMaxRetry,
    parameter int unsigned CLEAR_WINDOW = DefClearWindow,
    parameter int unsigned ACK_TIMEOUT  = DefAckTimeout,
    parameter int unsigned CNT_WIDTH    = DefCntWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           we_a_i,
    input  logic                           we_b_i,
    input  logic                           mismatch_i,
    input  logic                           recover_done_i,
    output logic                           commit_o,
    output logic                           halt_o,
    output logic                           recover_o,
    output logic                           fatal_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o,
    output logic [CNT_WIDTH-1:0]           err_total_o
);

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
    localparam int unsigned QuietW = $clog2(CLEAR_WINDOW + 1);
    localparam int unsigned TmoW   = $clog2(ACK_TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [RetryW-1:0]    retry_q, retry_d;
    logic [QuietW-1:0]    quiet_q, quiet_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] err_total_q, err_total_d;

    logic any_we, err, retry_max, quiet_full, tmo_hit;

    // A mismatch only matters when a core is actually trying to write.
    assign any_we     = we_a_i | we_b_i;
    assign err        = mismatch_i & any_we;
    assign retry_max  = (retry_q == RetryW'(MAX_RETRY));
    assign quiet_full = (quiet_q == QuietW'(CLEAR_WINDOW - 1));
    assign tmo_hit    = (tmo_q == TmoW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            retry_q     <= '0;
            quiet_q     <= '0;
            tmo_q       <= '0;
            err_total_q <= '0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            quiet_q     <= quiet_d;
            tmo_q       <= tmo_d;
            err_total_q <= err_total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (err) state_d = StHalt;
            StHalt:    state_d = retry_max ? StFatal : StRecover;
            // Acknowledge wins over a timeout landing in the same cycle.
            StRecover: begin
                if (recover_done_i) begin
                    state_d = StRun;
                end else if (tmo_hit) begin
                    state_d = StFatal;
                end
            end
            StFatal:   state_d = StFatal;
            default:   state_d = StRun;
        endcase
    end

    always_comb begin
        retry_d     = retry_q;
        quiet_d     = quiet_q;
        tmo_d       = '0;
        err_total_d = err_total_q;
        unique case (state_q)
            StRun: begin
                if (err) begin
                    quiet_d = '0;
                    if (err_total_q != '1) begin
                        err_total_d = err_total_q + 1'b1;
                    end
                end else if (quiet_full) begin
                    quiet_d = '0;
                    retry_d = '0;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            StHalt:    if (!retry_max) retry_d = retry_q + 1'b1;
            StRecover: tmo_d = tmo_q + 1'b1;
            default:   ;
        endcase
    end

    // Commit is gated by reset since the register file must see no write while held.
    always_comb begin
        commit_o  = 1'b0;
        halt_o    = 1'b1;
        recover_o = 1'b0;
        fatal_o   = 1'b0;
        unique case (state_q)
            StRun: begin
                halt_o   = 1'b0;
                commit_o = rst_ni & any_we & ~mismatch_i;
            end
            StRecover: recover_o = 1'b1;
            StFatal:   fatal_o   = 1'b1;
            default:   ;
        endcase
    end

    assign retry_cnt_o = retry_q;
    assign err_total_o = err_total_q;

endmodule

// File: tb/tb_lockstep_recovery_ctrl.sv
// Directed bench for lockstep_recovery_ctrl at default parameters.
module tb_lockstep_recovery_ctrl;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       we_a = 1'b0, we_b = 1'b0, mismatch = 1'b0, recover_done = 1'b0;
    logic       commit, halt, recover, fatal;
    logic [1:0] retry_cnt;
    logic [7:0] err_total;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    lockstep_recovery_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .we_a_i         (we_a),
        .we_b_i         (we_b),
        .mismatch_i     (mismatch),
        .recover_done_i (recover_done),
        .commit_o       (commit),
        .halt_o         (halt),
        .recover_o      (recover),
        .fatal_o        (fatal),
        .retry_cnt_o    (retry_cnt),
        .err_total_o    (err_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic c, input logic h, input logic r,
                        input logic f);
        chk({tag, ".commit"}, commit, c);
        chk({tag, ".halt"}, halt, h);
        chk({tag, ".recover"}, recover, r);
        chk({tag, ".fatal"}, fatal, f);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic a, input logic b, input logic m, input logic d);
        we_a = a;
        we_b = b;
        mismatch = m;
        recover_done = d;
    endtask

    // Error in RUN, then acknowledge on the given RECOVER cycle (1-based).
    task automatic err_recover(input int ack_cycle);
        drive(1, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        repeat (ack_cycle - 1) tick();
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state, with a clean write presented to prove commit is held low
        drive(1, 1, 0, 0);
        #3;
        outs("reset", 0, 0, 0, 0);
        chk("reset.retry", retry_cnt, 0);
        chk("reset.errtot", err_total, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Clean dual writes for 100 cycles
        for (int i = 0; i < 100; i++) begin
            #1;
            chk("run100.commit", commit, 1);
            chk("run100.halt", halt, 0);
            tick();
        end
        chk("run100.retry", retry_cnt, 0);
        chk("run100.errtot", err_total, 0);

        // Mismatch without a write, and stray ack in RUN, are ignored
        drive(0, 0, 1, 0);
        #1;
        outs("nowrite", 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1);
        tick();
        outs("ignored", 0, 0, 0, 0);
        chk("ignored.errtot", err_total, 0);

        // Single error, ack on 5th RECOVER cycle
        drive(1, 0, 1, 0);
        #1;
        outs("err1.run", 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 1);
        #1;
        outs("err1.halt", 0, 1, 0, 0);
        chk("err1.halt.retry", retry_cnt, 0);
        chk("err1.halt.errtot", err_total, 1);
        tick();
        drive(1, 1, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) recover_done = 1'b1;
            #1;
            outs("err1.recover", 0, 1, 1, 0);
            chk("err1.recover.retry", retry_cnt, 1);
            tick();
        end
        drive(0, 0, 0, 0);
        #1;
        outs("err1.back", 0, 0, 0, 0);
        chk("err1.back.retry", retry_cnt, 1);
        chk("err1.back.errtot", err_total, 1);

        // 64 quiet cycles clear the retry count
        drive(1, 1, 0, 0);
        repeat (63) tick();
        chk("clear.before", retry_cnt, 1);
        tick();
        chk("clear.after", retry_cnt, 0);
        err_recover(1);
        chk("clear.next.retry", retry_cnt, 1);
        chk("clear.next.errtot", err_total, 2);
        chk("clear.next.halt", halt, 0);

        // Error on the 64th quiet cycle beats the clear
        drive(1, 1, 0, 0);
        repeat (63) tick();
        drive(1, 1, 1, 0);
        tick();
        chk("prio.halt.retry", retry_cnt, 1);
        drive(0, 0, 0, 0);
        tick();
        chk("prio.recover.retry", retry_cnt, 2);
        recover_done = 1'b1;
        tick();
        recover_done = 1'b0;
        chk("prio.errtot", err_total, 3);

        // Four errors with short quiet gaps end in FATAL
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            err_recover(1);
            drive(1, 1, 0, 0);
            repeat (5) tick();
            chk("retry.step", retry_cnt, n);
        end
        drive(1, 1, 1, 0);
        tick();
        outs("fourth.halt", 0, 1, 0, 0);
        drive(1, 1, 0, 1);
        tick();
        outs("fatal", 0, 1, 0, 1);
        chk("fatal.errtot", err_total, 4);
        chk("fatal.retry", retry_cnt, 3);
        repeat (10) tick();
        outs("fatal.sticky", 0, 1, 0, 1);

        // Asynchronous reset out of FATAL
        rst_ni = 1'b0;
        #1;
        outs("rst_fatal", 0, 0, 0, 0);
        chk("rst_fatal.retry", retry_cnt, 0);
        chk("rst_fatal.errtot", err_total, 0);
        drive(0, 0, 0, 0);
        tick();
        rst_ni = 1'b1;

        // No ack for 16 RECOVER cycles -> FATAL
        drive(1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            chk("tmo.recover", recover, 1);
            tick();
        end
        outs("tmo.fatal", 0, 1, 0, 1);

        // Ack on cycle 16 returns to RUN
        do_reset();
        drive(0, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        repeat (15) tick();
        recover_done = 1'b1;
        #1;
        outs("ack16.last", 0, 1, 1, 0);
        tick();
        outs("ack16.run", 0, 0, 0, 0);
        chk("ack16.retry", retry_cnt, 1);

        // Reset pulsed mid-RECOVER
        drive(1, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("rst_rec.pre", recover, 1);
        rst_ni = 1'b0;
        #1;
        outs("rst_rec", 0, 0, 0, 0);
        chk("rst_rec.retry", retry_cnt, 0);
        chk("rst_rec.errtot", err_total, 0);
        tick();
        rst_ni = 1'b1;
        #1;
        outs("rst_rec.run", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
